// File: rtl/quad_gen.sv
// Quadrature signal generator: a signed velocity feeds a phase accumulator whose
// carries become Gray-coded A/B edges, with a dwell limiter and a periodic index Z.
module quad_gen #(
  parameter int W  = 14,
  parameter int VW = 12,
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [VW-1:0] vel,
  input  logic [DW-1:0] dwell,
  input  logic [W-1:0]  zper,
  input  logic          pos_clr,
  input  logic          ovr_clr,
  output logic          A,
  output logic          B,
  output logic          Z,
  output logic [W-1:0]  pos,
  output logic          ovr
);

  localparam logic [W-1:0]  W_ONE  = W'(1);
  localparam logic [DW-1:0] DW_ONE = DW'(1);
  localparam logic [VW-1:0] VW_ONE = VW'(1);

  logic [AW-1:0] acc_q, acc_d;
  logic [W-1:0]  pos_q, pos_d;
  logic [W-1:0]  icnt_q, icnt_d;
  logic [W-1:0]  zper_r_q, zper_r_d;
  logic [1:0]    ab_q, ab_d;
  logic          z_q, z_d;
  logic [DW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic          pdir_q, pdir_d;
  logic          ovr_q, ovr_d;

  logic [VW-1:0] vel_mag;
  logic [AW:0]   acc_sum;
  logic          req;
  logic          consume;

  // Up order 00->10->11->01 keeps newA^oldB=1, the counter's up sense.
  function automatic logic [1:0] gray_step(input logic [1:0] ab, input logic up);
    if (up) begin
      case (ab)
        2'b00:   return 2'b10;
        2'b10:   return 2'b11;
        2'b11:   return 2'b01;
        default: return 2'b00;
      endcase
    end else begin
      case (ab)
        2'b00:   return 2'b01;
        2'b01:   return 2'b11;
        2'b11:   return 2'b10;
        default: return 2'b00;
      endcase
    end
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    acc_d    = acc_q;
    pos_d    = pos_q;
    icnt_d   = icnt_q;
    zper_r_d = zper_r_q;
    ab_d     = ab_q;
    z_d      = z_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    pdir_d   = pdir_q;
    ovr_d    = ovr_q;

    // Two's-complement magnitude read as unsigned, so the most negative word maps to 2^(VW-1).
    vel_mag  = vel[VW-1] ? (~vel + VW_ONE) : vel;
    acc_sum  = {1'b0, acc_q} + {{(AW+1-VW){1'b0}}, vel_mag};
    req      = en & acc_sum[AW];
    consume  = pend_q & (timer_q == '0);

    if (ovr_clr) ovr_d = 1'b0;

    if (pos_clr) begin
      acc_d    = '0;
      pos_d    = '0;
      icnt_d   = '0;
      ab_d     = 2'b00;
      pend_d   = 1'b0;
      timer_d  = '0;
      zper_r_d = zper;
      z_d      = (zper != '0);
    end else begin
      if (en) acc_d = acc_sum[AW-1:0];
      if (timer_q != '0) timer_d = timer_q - DW_ONE;

      if (consume) begin
        pend_d  = 1'b0;
        ab_d    = gray_step(ab_q, pdir_q);
        pos_d   = pdir_q ? pos_q + W_ONE : pos_q - W_ONE;
        timer_d = dwell;
        if (zper_r_q == '0)
          icnt_d = '0;
        else if (pdir_q)
          icnt_d = (icnt_q == zper_r_q - W_ONE) ? '0 : icnt_q + W_ONE;
        else
          icnt_d = (icnt_q == '0) ? zper_r_q - W_ONE : icnt_q - W_ONE;
        z_d = (zper_r_q != '0) && (icnt_d == '0);
      end

      // A slot freed this cycle can take the new request; otherwise it is lost.
      if (req) begin
        if (pend_q && !consume) begin
          ovr_d = 1'b1;
        end else begin
          pend_d = 1'b1;
          pdir_d = ~vel[VW-1];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      pos_q    <= '0;
      icnt_q   <= '0;
      zper_r_q <= '0;
      ab_q     <= 2'b00;
      z_q      <= 1'b0;
      timer_q  <= '0;
      pend_q   <= 1'b0;
      pdir_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      pos_q    <= pos_d;
      icnt_q   <= icnt_d;
      zper_r_q <= zper_r_d;
      ab_q     <= ab_d;
      z_q      <= z_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      pdir_q   <= pdir_d;
      ovr_q    <= ovr_d;
    end
  end

  assign A   = ab_q[1];
  assign B   = ab_q[0];
  assign Z   = z_q;
  assign pos = pos_q;
  assign ovr = ovr_q;

endmodule

// File: tb/tb_quad_gen.sv
// Directed self-checking bench for quad_gen: edge timing, Gray order, index,
// dwell/overrun, a decoded loopback run, enable hold and clear priority.
module tb_quad_gen;
  localparam int W = 14, VW = 12, AW = 16, DW = 8;
  localparam logic [VW-1:0] V_UP = 12'd2047;  // largest positive step; carries at 32k+1 for k<64
  localparam logic [VW-1:0] V_DN = 12'h800;   // -2048, magnitude 2048; carries at 32k

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, pos_clr = 1'b0, ovr_clr = 1'b0;
  logic [VW-1:0] vel = '0;
  logic [DW-1:0] dwell = '0;
  logic [W-1:0]  zper = '0;
  logic A, B, Z, ovr;
  logic [W-1:0] pos;
  int n_checks = 0, n_fail = 0;

  quad_gen #(.W(W), .VW(VW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .vel(vel), .dwell(dwell), .zper(zper),
    .pos_clr(pos_clr), .ovr_clr(ovr_clr), .A(A), .B(B), .Z(Z), .pos(pos), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear(input logic [W-1:0] zp);
    en = 1'b0; zper = zp; pos_clr = 1'b1; ovr_clr = 1'b1;
    tick(1);
    pos_clr = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic wait_pos(output int ncyc, output bit zchg);
    logic [W-1:0] p0;
    logic z0;
    p0 = pos; z0 = Z; ncyc = 0; zchg = 1'b0;
    do begin
      tick(1); ncyc++;
      if (pos === p0 && Z !== z0) zchg = 1'b1;
    end while (pos === p0 && ncyc < 100);
  endtask

  task automatic test_reset;
    vel = '0; dwell = '0; zper = '0; en = 1'b0;
    #12;
    n_checks++; if ({A, B, Z} !== 3'b000) begin n_fail++; $display("FAIL reset_abz: got %b expected 000", {A, B, Z}); end
    n_checks++; if (pos !== '0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", pos); end
    n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    @(negedge clk) rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_forward;
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    clear('0);
    dwell = '0; vel = V_UP; en = 1'b1;
    tick(33);
    n_checks++; if ({A, B} !== 2'b00 || pos !== '0) begin n_fail++; $display("FAIL fwd_latency: got AB=%b pos=%0d expected AB=00 pos=0", {A, B}, pos); end
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n_checks++; if ({A, B} !== seq[k % 4] || pos !== W'(k + 1)) begin n_fail++; $display("FAIL fwd_edge%0d: got AB=%b pos=%0d expected AB=%b pos=%0d", k, {A, B}, pos, seq[k % 4], k + 1); end
      tick(31);
      n_checks++; if ({A, B} !== seq[k % 4]) begin n_fail++; $display("FAIL fwd_hold%0d: got AB=%b expected %b", k, {A, B}, seq[k % 4]); end
    end
    n_checks++; if (Z !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL fwd_z_ovr: got Z=%b ovr=%b expected 0 0", Z, ovr); end
  endtask

  task automatic test_reverse;
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    clear('0);
    dwell = '0; vel = V_DN; en = 1'b1;
    tick(32);
    n_checks++; if ({A, B} !== 2'b00 || pos !== '0) begin n_fail++; $display("FAIL rev_latency: got AB=%b pos=%0d expected AB=00 pos=0", {A, B}, pos); end
    for (int k = 0; k < 4; k++) begin
      tick(1);
      n_checks++; if ({A, B} !== seq[k] || pos !== W'(16383 - k)) begin n_fail++; $display("FAIL rev_edge%0d: got AB=%b pos=%0d expected AB=%b pos=%0d", k, {A, B}, pos, seq[k], 16383 - k); end
      tick(31);
    end
  endtask

  task automatic test_index;
    int nc, ep;
    bit zc;
    clear(14'd4);
    n_checks++; if (Z !== 1'b1 || pos !== '0) begin n_fail++; $display("FAIL idx_clear: got Z=%b pos=%0d expected Z=1 pos=0", Z, pos); end
    dwell = '0; vel = V_UP; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_pos(nc, zc);
      n_checks++; if (nc >= 100 || zc || nc < 32) begin n_fail++; $display("FAIL idx_up_wait%0d: got %0d clk zchg=%b expected 32..99 clk stable Z", k, nc, zc); end
      n_checks++; if (pos !== W'(k) || Z !== (k % 4 == 0)) begin n_fail++; $display("FAIL idx_up%0d: got pos=%0d Z=%b expected pos=%0d Z=%b", k, pos, Z, k, (k % 4 == 0)); end
    end
    vel = V_DN;
    for (int j = 1; j <= 9; j++) begin
      ep = (8 - j + 16384) % 16384;
      wait_pos(nc, zc);
      n_checks++; if (nc >= 100 || zc) begin n_fail++; $display("FAIL idx_dn_wait%0d: got %0d clk zchg=%b expected <100 clk stable Z", j, nc, zc); end
      n_checks++; if (pos !== W'(ep) || Z !== (ep % 4 == 0)) begin n_fail++; $display("FAIL idx_dn%0d: got pos=%0d Z=%b expected pos=%0d Z=%b", j, pos, Z, ep, (ep % 4 == 0)); end
    end
    vel = V_UP;
    wait_pos(nc, zc);
    n_checks++; if (nc >= 100 || pos !== '0 || Z !== 1'b1) begin n_fail++; $display("FAIL idx_wrap_up: got pos=%0d Z=%b after %0d clk expected pos=0 Z=1", pos, Z, nc); end
  endtask

  task automatic test_dwell_ovr;
    int exp_t [9];
    int edge_t [$];
    logic [W-1:0] pp;
    exp_t = '{34, 75, 116, 157, 198, 239, 280, 321, 362};
    clear('0);
    dwell = 8'd40; vel = V_UP; en = 1'b1;
    pp = pos;
    for (int cyc = 1; cyc <= 362; cyc++) begin
      ovr_clr = (cyc == 194 || cyc == 353);
      tick(1);
      if (pos !== pp) edge_t.push_back(cyc);
      pp = pos;
      if (cyc == 192 || cyc == 194 || cyc == 352) begin
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear_at%0d: got %b expected 0", cyc, ovr); end
      end
      if (cyc == 193 || cyc == 353) begin
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set_at%0d: got %b expected 1", cyc, ovr); end
      end
    end
    ovr_clr = 1'b0;
    n_checks++; if (edge_t.size() != 9) begin n_fail++; $display("FAIL dwell_edge_count: got %0d expected 9", edge_t.size()); end
    for (int i = 0; i < 9 && i < edge_t.size(); i++) begin
      n_checks++; if (edge_t[i] != exp_t[i]) begin n_fail++; $display("FAIL dwell_edge%0d_time: got %0d expected %0d", i, edge_t[i], exp_t[i]); end
    end
  endtask

  task automatic test_loopback;
    logic [W-1:0] dec;
    logic [1:0] prev_ab, cur;
    logic prev_z;
    int cyc, zhi, minw, zrise, zlatch, illegal;
    clear(14'd100);
    dwell = 8'd8; en = 1'b1;
    dec = '0; prev_ab = {A, B}; prev_z = Z;
    cyc = 0; zhi = 0; minw = 1000; zrise = 0; zlatch = -1; illegal = 0;
    for (int phase = 0; phase < 2; phase++) begin
      vel = phase ? V_DN : V_UP;
      while (dec != (phase ? W'(700) : W'(1000)) && cyc < 60000) begin
        tick(1); cyc++;
        cur = {A, B};
        if (cur != prev_ab) begin
          if ((cur ^ prev_ab) == 2'b11) illegal++;
          else if (cur[1] ^ prev_ab[0]) dec = dec + W'(1);
          else dec = dec - W'(1);
        end
        prev_ab = cur;
        if (Z && !prev_z) begin zrise++; zlatch = int'(dec); end
        if (Z) zhi++;
        else if (prev_z) begin if (zhi < minw) minw = zhi; zhi = 0; end
        prev_z = Z;
      end
    end
    n_checks++; if (cyc >= 60000) begin n_fail++; $display("FAIL loop_timeout: got %0d clk expected <60000", cyc); end
    n_checks++; if (dec !== W'(700) || pos !== W'(700)) begin n_fail++; $display("FAIL loop_count: got dec=%0d pos=%0d expected 700 700", dec, pos); end
    n_checks++; if (illegal != 0) begin n_fail++; $display("FAIL loop_gray: got %0d double transitions expected 0", illegal); end
    n_checks++; if (zrise != 13 || zlatch != 700) begin n_fail++; $display("FAIL loop_index: got rises=%0d latch=%0d expected 13 700", zrise, zlatch); end
    n_checks++; if (minw < 8 || Z !== 1'b1 || ovr !== 1'b0) begin n_fail++; $display("FAIL loop_zwidth: got minw=%0d Z=%b ovr=%b expected >=8 1 0", minw, Z, ovr); end
  endtask

  task automatic test_enable_hold;
    clear('0);
    dwell = 8'd50; vel = V_UP; en = 1'b1;
    tick(70);
    en = 1'b0;
    tick(14);
    n_checks++; if (pos !== W'(1)) begin n_fail++; $display("FAIL en_pend_wait: got pos=%0d expected 1", pos); end
    tick(1);
    n_checks++; if (pos !== W'(2) || {A, B} !== 2'b11) begin n_fail++; $display("FAIL en_pend_drain: got pos=%0d AB=%b expected 2 11", pos, {A, B}); end
    tick(100);
    n_checks++; if (pos !== W'(2) || {A, B} !== 2'b11) begin n_fail++; $display("FAIL en_frozen: got pos=%0d AB=%b expected 2 11", pos, {A, B}); end
    en = 1'b1;
    tick(27);
    n_checks++; if (pos !== W'(2)) begin n_fail++; $display("FAIL en_acc_held_early: got pos=%0d expected 2", pos); end
    tick(1);
    n_checks++; if (pos !== W'(3) || {A, B} !== 2'b01) begin n_fail++; $display("FAIL en_acc_held: got pos=%0d AB=%b expected 3 01", pos, {A, B}); end
  endtask

  task automatic test_clr_priority;
    clear('0);
    dwell = '0; vel = V_UP; en = 1'b1;
    tick(32);
    pos_clr = 1'b1;
    tick(1);
    pos_clr = 1'b0;
    n_checks++; if (pos !== '0 || {A, B} !== 2'b00 || ovr !== 1'b0) begin n_fail++; $display("FAIL clr_req: got pos=%0d AB=%b ovr=%b expected 0 00 0", pos, {A, B}, ovr); end
    tick(1);
    n_checks++; if (pos !== '0 || {A, B} !== 2'b00) begin n_fail++; $display("FAIL clr_no_edge: got pos=%0d AB=%b expected 0 00", pos, {A, B}); end
    tick(32);
    n_checks++; if (pos !== '0) begin n_fail++; $display("FAIL clr_acc_zero_early: got pos=%0d expected 0", pos); end
    tick(1);
    n_checks++; if (pos !== W'(1) || {A, B} !== 2'b10) begin n_fail++; $display("FAIL clr_acc_zero: got pos=%0d AB=%b expected 1 10", pos, {A, B}); end
  endtask

  task automatic test_async_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (pos !== '0 || {A, B, Z} !== 3'b000 || ovr !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pos=%0d ABZ=%b ovr=%b expected 0 000 0", pos, {A, B, Z}, ovr); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_index();
    test_dwell_ovr();
    test_loopback();
    test_enable_hold();
    test_clr_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
